serial_code_converter: RTL and testbench
========================================

Name: serial_code_converter

Overview:
- Bit-serial, LSB-first converter between Excess-3 and BCD. It converts frames of NUM_DIGITS 4-bit digits, least-significant digit first.
- Z is a Mealy output and is valid in the same cycle as X, so downstream serial logic samples X and Z on the same edge.
- Adds the following on top of the single-digit converter:
  - bidirectional mode;
  - bit-valid qualifier;
  - per-digit range checking;
  - parallel frame capture register.

Parameters:
- NUM_DIGITS, 2, digits per frame (>=1).
- IDX_W, (NUM_DIGITS>1 ? $clog2(NUM_DIGITS) : 1), digit index width (derived, do not override).

Ports:
- Clk  in  1  clock, rising-edge.
- Rst  in  1  reset, asynchronous, active-high.
- En  in  1  bit qualifier; X is consumed only in cycles with En=1.
- Mode  in  1  0: Excess-3 -> BCD (subtract 3); 1: BCD -> Excess-3 (add 3).
- X  in  1  serial input bit.
- Z  out  1  serial converted bit, combinational from X and state.
- BitIdx  out  2  position of the next bit within the digit.
- DigitIdx  out  IDX_W  current digit within the frame.
- DigitDone  out  1  one-cycle pulse after the 4th bit of a digit.
- Err  out  1  invalid-digit indication.
- FrameDone  out  1  one-cycle pulse after the last bit of a frame.
- DOut  out  4*NUM_DIGITS  converted frame; digit 0 sits in [3:0].

Behaviour:
- Reset (async, Rst=1) clears all of the following:
  - BitIdx=0, DigitIdx=0, carry/borrow=0;
  - DigitDone=0, FrameDone=0, Err=0;
  - DOut=0, input shift reg=0, latched mode=0.
- Z is not a register. It is X^k^c, so Z=X^1 at bit 0 right after reset.
- Constant k per bit: bit0=1, bit1=1, bit2=0, bit3=0 (value 3).
- Mode latch:
  - Mode is sampled when En=1 at BitIdx=0 and DigitIdx=0, and held for the rest of the frame.
  - The bit at frame start uses the live Mode.
  - Mode changes mid-frame are ignored.
- Per accepted bit (En=1, rising edge):
  - Subtract mode: c' = (~X&(k|c)) | (k&c).
  - Add mode: c' = (X&k) | (X&c) | (k&c).
  - Z is shifted into the output digit register and X into the input shift register.
  - BitIdx increments mod 4.
  - At BitIdx=3, c is forced to 0 (the final carry/borrow is discarded) and DigitIdx advances, wrapping to 0 after NUM_DIGITS-1.
- En=0: all state holds and Z remains combinational (don't care). DigitDone and FrameDone deassert.
- Latency: DigitDone rises on the edge that accepts bit 3 and lasts one cycle.
- Err range check, evaluated on the full 4-bit input digit at that edge:
  - Subtract mode: invalid if digit <3 or >12.
  - Add mode: invalid if digit >9.
  - Without the macro (see Optional Feature), Err is a one-cycle pulse coincident with DigitDone.
- Frame completion:
  - FrameDone pulses on the edge that accepts bit 3 of digit NUM_DIGITS-1.
  - On the same edge, DOut loads all converted digits, including the one just completed.
  - DOut holds until the next frame completes. Invalid digits are still converted and loaded.
- Back-to-back: a new frame may start in the cycle after FrameDone with no gap.
- Reset mid-frame discards the partial digit and frame. The next accepted bit is bit 0 of digit 0, and DOut returns to 0.

Optional Feature:
- Macro: SERIAL_CONV_ERR_STICKY_EN.
- Defined:
  - Err sets on any invalid digit and stays high through following digits and frames.
  - Err clears only on Rst, or on the edge accepting bit 0 of a new frame, when the previous frame was error-free.
  - In short, Err reflects "last completed frame or current frame contains an invalid digit".
- Undefined: Err is the per-digit pulse described in Behaviour.

Test Plan:
- Mode=0, En=1, X=1,0,1,0 (Excess-3 0101) -> Z=0,1,0,0 (BCD 0010); DigitDone pulses after the 4th bit; Err=0.
- Mode=1, X=1,1,1,0 (BCD 0111) -> Z=0,1,0,1 (Excess-3 1010); Err=0.
- NUM_DIGITS=2, Mode=0, digit0=1100, digit1=0100 LSB-first -> FrameDone after bit 8, DOut=8'h19; DigitIdx goes 0,1, then back to 0.
- Mode=0, digit X=1,0,0,0 (0001) -> Err pulses with DigitDone. Mode=1, digit 1010 -> Err. With the sticky macro, Err stays high until the following clean frame starts.
- En toggled 1,0,0,1,... during a digit, plus a Mode flip mid-frame -> Z sequence, DOut and pulse timing are identical to the En-always-1 run; the Mode change takes effect only at the next frame.
- Rst pulsed after 2 bits of digit 1 -> all outputs 0 immediately (async). The subsequent 8 bits form a fresh frame that converts correctly.

Source files
------------

// File: rtl/serial_code_converter.sv
// serial_code_converter: LSB-first serial Excess-3 <-> BCD converter over NUM_DIGITS-digit frames.
// Define SERIAL_CONV_ERR_STICKY_EN to hold Err across digits/frames instead of pulsing per digit.
module serial_code_converter #(
   parameter int NUM_DIGITS = 2,
   parameter int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    En,
   input  logic                    Mode,
   input  logic                    X,
   output logic                    Z,
   output logic [1:0]              BitIdx,
   output logic [IDX_W-1:0]        DigitIdx,
   output logic                    DigitDone,
   output logic                    Err,
   output logic                    FrameDone,
   output logic [4*NUM_DIGITS-1:0] DOut
);
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

   logic c, c_next, mode_l, k, start, mode_eff, last_bit, last_dig, bad;
   logic [2:0] in_sr, out_sr;
   logic [3:0] in_dig, out_dig;
   logic [DW-1:0] acc, acc_next;

   always_comb begin
      start = BitIdx == 2'd0 && DigitIdx == '0;
      mode_eff = start ? Mode : mode_l;
      k = ~BitIdx[1];
      Z = X ^ k ^ c;
      c_next = mode_eff ? (X & k) | (X & c) | (k & c) : (~X & (k | c)) | (k & c);
      last_bit = BitIdx == 2'd3;
      last_dig = DigitIdx == LAST;
      in_dig = {X, in_sr};
      out_dig = {Z, out_sr};
      bad = mode_eff ? in_dig > 4'd9 : (in_dig < 4'd3 || in_dig > 4'd12);
      // completed digits enter at the top so digit 0 lands in [3:0] after a full frame
      acc_next = (acc >> 4) | (DW'(out_dig) << (DW - 4));
   end

   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         c <= 1'b0;
         mode_l <= 1'b0;
         BitIdx <= 2'd0;
         DigitIdx <= '0;
         in_sr <= '0;
         out_sr <= '0;
         acc <= '0;
         DOut <= '0;
         DigitDone <= 1'b0;
         FrameDone <= 1'b0;
      end else begin
         DigitDone <= En && last_bit;
         FrameDone <= En && last_bit && last_dig;
         if (En) begin
            in_sr <= in_dig[3:1];
            out_sr <= out_dig[3:1];
            BitIdx <= BitIdx + 2'd1;
            c <= last_bit ? 1'b0 : c_next;
            if (start) mode_l <= Mode;
            if (last_bit) begin
               acc <= acc_next;
               DigitIdx <= last_dig ? '0 : DigitIdx + IDX_W'(1);
               if (last_dig) DOut <= acc_next;
            end
         end
      end

`ifdef SERIAL_CONV_ERR_STICKY_EN
   logic cur_bad, prev_bad;

   // prev_bad remembers whether the last completed frame held an invalid digit
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         Err <= 1'b0;
         cur_bad <= 1'b0;
         prev_bad <= 1'b0;
      end else if (En) begin
         Err <= (start ? prev_bad : Err) | (last_bit & bad);
         cur_bad <= (start ? 1'b0 : cur_bad) | (last_bit & bad);
         if (last_bit && last_dig) prev_bad <= cur_bad | bad;
      end
`else
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) Err <= 1'b0;
      else Err <= En && last_bit && bad;
`endif
endmodule

// File: tb/tb_serial_code_converter.sv
// tb_serial_code_converter: directed frames checked against a digit-level arithmetic model.
module tb_serial_code_converter;
   localparam int N = 2;
   localparam int DW = 4 * N;
`ifdef SERIAL_CONV_ERR_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic Clk = 1'b0, Rst = 1'b1, En = 1'b0, Mode = 1'b0, X = 1'b0;
   logic Z, DigitDone, Err, FrameDone;
   logic [1:0] BitIdx;
   logic [0:0] DigitIdx;
   logic [DW-1:0] DOut;

   serial_code_converter #(.NUM_DIGITS(N)) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .X(X), .Z(Z),
      .BitIdx(BitIdx), .DigitIdx(DigitIdx), .DigitDone(DigitDone),
      .Err(Err), .FrameDone(FrameDone), .DOut(DOut)
   );

   always #5 Clk = ~Clk;

   int tests = 0, fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: digits as integers, converted value = digit +/- 3 mod 16
   int m_bit, m_dig, m_part;
   int m_acc [N];
   logic m_mode, m_dd, m_fd, m_err, m_cur_bad, m_prev_bad;
   logic [DW-1:0] m_dout;

   always @(posedge Clk or posedge Rst) begin : mdl
      int d;
      logic em, bad;
      if (Rst) begin
         m_bit = 0; m_dig = 0; m_part = 0; m_mode = 0;
         m_dd = 0; m_fd = 0; m_err = 0; m_cur_bad = 0; m_prev_bad = 0; m_dout = '0;
      end else begin
         m_dd = 0; m_fd = 0;
         if (!STICKY) m_err = 0;
         if (En) begin
            em = (m_bit == 0 && m_dig == 0) ? Mode : m_mode;
            if (m_bit == 0 && m_dig == 0) begin
               m_mode = Mode;
               m_prev_bad = m_cur_bad;
               m_cur_bad = 0;
            end
            d = m_part | (int'(X) << m_bit);
            if (m_bit < 3) begin
               m_part = d;
               m_bit++;
            end else begin
               bad = em ? (d > 9) : (d < 3 || d > 12);
               m_acc[m_dig] = (em ? d + 3 : d - 3) & 15;
               m_dd = 1;
               if (!STICKY) m_err = bad;
               m_cur_bad = m_cur_bad | bad;
               if (m_dig == N - 1) begin
                  m_fd = 1;
                  for (int i = 0; i < N; i++) m_dout[4*i +: 4] = 4'(m_acc[i]);
                  m_dig = 0;
               end else m_dig++;
               m_bit = 0;
               m_part = 0;
            end
            if (STICKY) m_err = m_prev_bad | m_cur_bad;
         end
      end
   end

   always @(negedge Clk) begin : cmp
      int d, conv;
      logic em;
      chk("BitIdx", BitIdx, m_bit);
      chk("DigitIdx", DigitIdx, m_dig);
      chk("DigitDone", DigitDone, m_dd);
      chk("FrameDone", FrameDone, m_fd);
      chk("Err", Err, m_err);
      chk("DOut", DOut, m_dout);
      if (En && !Rst) begin
         em = (m_bit == 0 && m_dig == 0) ? Mode : m_mode;
         d = m_part | (int'(X) << m_bit);
         conv = em ? d + 3 : d - 3;
         chk("Z", Z, (conv >> m_bit) & 1);
      end
   end

   task automatic bitx(input logic e, input logic m, input logic x, output logic z);
      @(posedge Clk);
      #1;
      En = e; Mode = m; X = x;
      @(negedge Clk);
      z = Z;
   endtask

   task automatic idle();
      logic zz;
      bitx(1'b0, Mode, 1'($urandom), zz);
   endtask

   task automatic digit(input logic m, input logic [3:0] d, input logic gap, output logic [3:0] zd);
      logic zz;
      for (int i = 0; i < 4; i++) begin
         bitx(1'b1, m, d[i], zz);
         zd[i] = zz;
         if (gap && i % 2 == 0) begin
            bitx(1'b0, ~m, 1'($urandom), zz);
            bitx(1'b0, ~m, 1'($urandom), zz);
         end
      end
   endtask

   task automatic frame(input logic m0, input logic m1, input logic [3:0] d0, input logic [3:0] d1,
                        input logic gap, output logic [7:0] zs);
      logic [3:0] z0, z1;
      digit(m0, d0, gap, z0);
      digit(m1, d1, gap, z1);
      idle();
      zs = {z1, z0};
   endtask

   logic [3:0] z4;
   logic [7:0] zs;
   logic zz;

   initial begin
      repeat (2) @(negedge Clk);
      chk("rst_dout", DOut, 0);
      chk("rst_z_bit0", Z, 1);
      #2 Rst = 1'b0;

      digit(1'b0, 4'b0101, 1'b0, z4);
      chk("t1_z", z4, 4'b0010);
      idle();
      chk("t1_digitdone", DigitDone, 1);
      chk("t1_digitidx", DigitIdx, 1);
      chk("t1_err", Err, 0);
      digit(1'b0, 4'd3, 1'b0, z4);
      idle();
      chk("t1_framedone", FrameDone, 1);
      chk("t1_dout", DOut, 8'h02);

      frame(1'b1, 1'b1, 4'b0111, 4'd0, 1'b0, zs);
      chk("t2_z", zs[3:0], 4'b1010);
      chk("t2_dout", DOut, 8'h3A);
      chk("t2_err", Err, 0);

      frame(1'b0, 1'b0, 4'd12, 4'd4, 1'b0, zs);
      chk("t3_z", zs, 8'h19);
      chk("t3_dout", DOut, 8'h19);
      chk("t3_digitidx", DigitIdx, 0);

      digit(1'b0, 4'd1, 1'b0, z4);
      idle();
      chk("t4_err_sub", Err, 1);
      digit(1'b0, 4'd5, 1'b0, z4);
      idle();
      chk("t4_err_after", Err, STICKY);
      digit(1'b1, 4'd10, 1'b0, z4);
      idle();
      chk("t4_err_add", Err, 1);
      chk("t4_z_add", z4, 4'hD);
      digit(1'b1, 4'd2, 1'b0, z4);
      idle();
      chk("t4_dout", DOut, 8'h5D);
      frame(1'b0, 1'b0, 4'd5, 4'd3, 1'b0, zs);
      chk("t4_clean_frame_err", Err, STICKY);
      frame(1'b0, 1'b0, 4'd5, 4'd3, 1'b0, zs);
      chk("t4_second_clean_err", Err, 0);

      frame(1'b0, 1'b1, 4'd12, 4'd4, 1'b1, zs);
      chk("t5_z", zs, 8'h19);
      chk("t5_dout", DOut, 8'h19);
      frame(1'b1, 1'b1, 4'd7, 4'd0, 1'b0, zs);
      chk("t5_next_mode", DOut, 8'h3A);

      frame(1'b0, 1'b0, 4'd3, 4'd12, 1'b0, zs);
      chk("b_sub_ok", DOut, 8'h90);
      frame(1'b0, 1'b0, 4'd2, 4'd13, 1'b0, zs);
      chk("b_sub_bad", DOut, 8'hAF);
      frame(1'b1, 1'b1, 4'd9, 4'd10, 1'b0, zs);
      chk("b_add", DOut, 8'hDC);

      digit(1'b0, 4'd5, 1'b0, z4);
      bitx(1'b1, 1'b0, 1'b1, zz);
      bitx(1'b1, 1'b0, 1'b0, zz);
      idle();
      chk("t6_pre_bitidx", BitIdx, 2);
      #2 Rst = 1'b1;
      #1;
      chk("t6_bitidx", BitIdx, 0);
      chk("t6_digitidx", DigitIdx, 0);
      chk("t6_dout", DOut, 0);
      #1 Rst = 1'b0;
      frame(1'b0, 1'b0, 4'd5, 4'd8, 1'b0, zs);
      chk("t6_frame", DOut, 8'h52);
      chk("t6_z", zs, 8'h52);

      repeat (3) idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
